y86_bus_mem: RTL
================

# y86_bus_mem

Byte-addressed memory responder for the y86 sequential core's system bus: it answers the core's fetch, load and store cycles on `bus_A/bus_in/bus_out/bus_WE/bus_RE`, seen here from the memory side. It also provides a byte-serial load port for preloading a program while the core is held in reset. It keeps saturating access counters and a sticky error flag for bench and debug use. It sits beside `y86_seq` at the top level and is the only bus target.

## Interface
- `AW`, 10: byte-address width; memory holds 2^AW bytes.
- `CW`, 16: width of access counters.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bus_A` input 32: byte address from the core.
- `bus_RE` input 1: read strobe; data is returned combinationally in the same cycle.
- `bus_WE` input 1: write strobe; the write commits at the rising edge.
- `bus_wdata` input 32: store data, driven by the core's `bus_out`.
- `bus_rdata` output 32: read data, feeding the core's `bus_in`.
- `ld_start` input 1: pulse that clears the load pointer to 0.
- `ld_valid` input 1: a load byte is offered.
- `ld_data` input 8: the load byte.
- `ld_ready` output 1: the load byte is accepted on this edge when `ld_valid` is also high.
- `ld_done` output 1: high when the load pointer equals 2^AW (memory full).
- `rd_count` output CW: number of accepted reads, saturating.
- `wr_count` output CW: number of accepted writes, saturating.
- `err` output 1: sticky error flag.

## Operation
- **Storage.** Byte array `mem[0:2^AW-1]`. Contents are not reset.
- **Address range.** An address is in range when `bus_A[31:AW]==0`. Byte lanes are `bus_A+i`, i=0..3, taken modulo 2^AW, so an access wraps at the top of memory.
- **Read.** `bus_rdata = {mem[a+3],mem[a+2],mem[a+1],mem[a]}` (little-endian, any byte alignment).
  - `bus_rdata` is combinational on `bus_A` whenever `bus_RE` is high.
  - When `bus_RE` is low, or the address is out of range, `bus_rdata` is 0.
- **Write.** On a rising edge with `bus_WE` high and the address in range, the four bytes of `bus_wdata` are written little-endian to a..a+3 (wrapping).
  - An out-of-range write is dropped and sets `err`.
- **Both strobes high.** The write commits and the read returns the pre-write contents. Both counters increment and `err` is set.
- **Counters.**
  - `rd_count` increments on each edge with `bus_RE` high.
  - `wr_count` increments on each edge with `bus_WE` high.
  - Both saturate at 2^CW-1 and never wrap.
- **Errors.** `err` is set by:
  - an out-of-range access,
  - both strobes high on the same edge,
  - `ld_valid` high while `ld_done` is high.

  `err` is cleared only by reset.
- **Load port.**
  - `ld_ready = !bus_WE && !ld_done`; a bus write takes priority.
  - An accepted byte is written to `mem[ptr]` and `ptr` increments (AW+1 bits).
  - `ld_start` has priority over acceptance in the same cycle: `ptr` is cleared to 0 and no byte is written.

## Timing
- **Reset values:** `rd_count`=0, `wr_count`=0, `err`=0, `ptr`=0, `ld_done`=0, `ld_ready`=1. `bus_rdata` is 0 whenever `bus_RE`=0.
- **Read latency:** 0 cycles (combinational), which matches the core fetching `IR <= bus_in` in the strobe cycle.
- **Write latency:** data is visible to a read in the cycle after the `bus_WE` edge.
- **Load port:** one byte per cycle at full rate. `ld_done` rises the cycle after byte 2^AW-1 is accepted.
- **Reset mid-load:** `ptr` returns to 0 asynchronously. Bytes already written stay in memory.
- All registered state responds only to `rst_n` (asynchronous) and to `clk` rising edges.

## Structure
- A shared package `y86_bus_pkg` holds:
  - the bus data width (32) and bytes per word (4),
  - the little-endian lane-ordering function,
  - the y86 opcode constants shared with the core.
- One sub-module, `y86_sat_counter` (parameter CW; inputs `inc`, `rst_n`, `clk`), is instantiated twice for the two access counters.
- The byte array, lane mux and load pointer stay in the top module.

## Test plan
- **Load, then fetch:** reset; stream bytes 0x01,0xC8,0x89,0xD8 → `ld_done`=0 and `ptr`=4. Then `bus_RE`=1 with `bus_A`=0 → `bus_rdata`=0xD889C801; `bus_A`=1 → 0x00D889C8.
- **Aligned and unaligned store:** store 0xDEADBEEF at `bus_A`=6 → next cycle a read at 6 returns 0xDEADBEEF, a read at 8 returns 0x0000DEAD, and `wr_count`=1.
- **Wrap-around (AW=10):** store 0x11223344 at `bus_A`=0x3FE → mem[0x3FE]=0x44, mem[0x3FF]=0x33, mem[0]=0x22, mem[1]=0x11; a read at 0x3FE returns 0x11223344.
- **Out of range:** write at `bus_A`=0x400 → memory unchanged and `err`=1. A read at 0x400 → `bus_rdata`=0.
- **Load contention and full:**
  - `ld_valid` held high with `bus_WE` pulsed → `ld_ready`=0 for that cycle only, and no byte is lost.
  - Fill all 1024 bytes → `ld_done`=1 and `ld_ready`=0; a further `ld_valid` sets `err`.
  - `ld_start` → `ptr`=0 and `ld_done`=0.
- **Counter saturation and reset (CW=4):** 20 read cycles → `rd_count`=15. Assert `rst_n`=0 mid-sequence → counters, `err` and `ptr` read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_bus_pkg.sv
// Shared definitions for the y86 system bus: widths, lane ordering, opcodes.
package y86_bus_pkg;

   localparam int unsigned DW  = 32;
   localparam int unsigned BPW = 4;

   // y86 instruction codes (upper nibble of the first instruction byte)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVL = 4'h2;
   localparam logic [3:0] I_IRMOVL = 4'h3;
   localparam logic [3:0] I_RMMOVL = 4'h4;
   localparam logic [3:0] I_MRMOVL = 4'h5;
   localparam logic [3:0] I_OPL    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHL  = 4'hA;
   localparam logic [3:0] I_POPL   = 4'hB;

   typedef struct packed {
      logic          re;
      logic          we;
      logic [DW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_req_t;

   // Byte lane i of a little-endian word (lane 0 is the lowest address)
   function automatic logic [7:0] le_lane(input logic [DW-1:0] w, input logic [1:0] i);
      return w[{i, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/y86_bus_mem_if.sv
// Core <-> memory system bus; master is the core, slave is the memory.
interface y86_bus_mem_if;
   import y86_bus_pkg::*;

   logic [DW-1:0] bus_A;
   logic          bus_RE;
   logic          bus_WE;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;

   modport master (output bus_A, output bus_RE, output bus_WE, output bus_wdata,
                   input  bus_rdata);
   modport slave  (input  bus_A, input  bus_RE, input  bus_WE, input  bus_wdata,
                   output bus_rdata);
endinterface

// File: rtl/y86_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module y86_sat_counter #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [CW-1:0] cnt
);
   localparam logic [CW-1:0] CNT_MAX = '1;

   // Count up on each enabled edge, stopping at the maximum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt <= '0;
      else if (inc && (cnt != CNT_MAX)) cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/y86_bus_mem.sv
// Byte-addressed bus memory for the y86 core with a byte-serial preload port.
module y86_bus_mem
   import y86_bus_pkg::*;
#(
   parameter int unsigned AW = 10,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   y86_bus_mem_if.slave  bus,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   output logic [CW-1:0] rd_count,
   output logic [CW-1:0] wr_count,
   output logic          err
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [7:0]    mem [DEPTH];
   logic [AW:0]   ptr;
   logic          in_range;
   logic          wr_en;
   logic          ld_acc;
   logic          err_set;
   logic [AW-1:0] lane_addr [BPW];

   // Address decode: range check and the four wrapping byte-lane addresses
   always_comb begin
      in_range = (bus.bus_A[DW-1:AW] == '0);
      for (int i = 0; i < BPW; i++) begin
         lane_addr[i] = bus.bus_A[AW-1:0] + AW'(i);
      end
   end

   // Strobe qualification, load handshake and error sources
   always_comb begin
      wr_en    = bus.bus_WE && in_range;
      ld_done  = ptr[AW];               // ptr never exceeds DEPTH, so the MSB marks full
      ld_ready = !bus.bus_WE && !ld_done;
      ld_acc   = ld_valid && ld_ready && !ld_start;
      err_set  = ((bus.bus_RE || bus.bus_WE) && !in_range)
               || (bus.bus_RE && bus.bus_WE)
               || (ld_valid && ld_done);
   end

   // Zero-latency little-endian read; quiet when not strobed or out of range
   always_comb begin
      bus.bus_rdata = '0;
      if (bus.bus_RE && in_range) begin
         for (int i = 0; i < BPW; i++) begin
            bus.bus_rdata[8*i +: 8] = mem[lane_addr[i]];
         end
      end
   end

   // Storage has no reset; a bus write excludes a load byte in the same cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BPW; i++) begin
            mem[lane_addr[i]] <= le_lane(bus.bus_wdata, 2'(i));
         end
      end else if (ld_acc) begin
         mem[ptr[AW-1:0]] <= ld_data;
      end
   end

   // Load pointer; a start pulse wins over an offered byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ptr <= '0;
      else if (ld_start) ptr <= '0;
      else if (ld_acc)   ptr <= ptr + (AW+1)'(1);
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

   y86_sat_counter #(.CW(CW)) u_rd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.bus_RE),
      .cnt   (rd_count)
   );

   y86_sat_counter #(.CW(CW)) u_wr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.bus_WE),
      .cnt   (wr_count)
   );
endmodule
